adder_tree_reduce_ctrl: RTL and testbench
=========================================

// Module: adder_tree_reduce_ctrl
// PURPOSE
//  Sequences a long-vector reduction through one adder_tree instance.
//  - A command gives a beat count B. The block streams B input beats of NUM_INPUTS lanes into the tree.
//  - It accumulates the B partial sums returned on the tree's start/start_out token pipeline.
//  - It presents one wide signed total on a valid/ready result port.
//  - It sits between the vector source and the tree. The tree's PIPE_STAGE_MASK popcount is passed in as TREE_LATENCY.
// PARAMETERS
//  NUM_INPUTS    8   lanes per beat; power of 2; must match the tree.
//  INPUT_WIDTH   8   signed lane width.
//  TREE_LATENCY  2   cycles from tree start to start_out; 0 = combinational tree.
//  MAX_BEATS     16  largest beat count per command.
//  TREE_WIDTH    INPUT_WIDTH+$clog2(NUM_INPUTS)            tree sum width.
//  ACC_WIDTH     TREE_WIDTH+$clog2(MAX_BEATS)              accumulator/result width.
//  CNT_WIDTH     $clog2(MAX_BEATS+1)                       beat counter width.
// PORTS
//  clk             in   1                       clock, rising edge.
//  rst             in   1                       asynchronous, active-high reset.
//  cmd_valid       in   1                       command offered.
//  cmd_ready       out  1                       high only in IDLE.
//  cmd_beats       in   CNT_WIDTH               beat count B; values >MAX_BEATS saturate to MAX_BEATS.
//  in_valid        in   1                       input beat offered.
//  in_ready        out  1                       high only in FEED.
//  in_data         in   NUM_INPUTS*INPUT_WIDTH  lane k at [k*INPUT_WIDTH +: INPUT_WIDTH], signed.
//  tree_inputs     out  NUM_INPUTS*INPUT_WIDTH  = in_data, combinational pass-through.
//  tree_start      out  1                       = in_valid & in_ready (beat issue).
//  tree_sum        in   TREE_WIDTH              tree sum_out, signed.
//  tree_start_out  in   1                       tree token; tree_sum is valid when high.
//  res_valid       out  1                       result held.
//  res_ready       in   1                       result consumer ready.
//  res_sum         out  ACC_WIDTH               signed total.
//  busy            out  1                       state != IDLE.
//  err             out  1                       sticky: tree token received while not expecting one.
// BEHAVIOUR
//  Reset: all registers clear asynchronously. State=IDLE; cmd_ready=1; in_ready=0; tree_start=0.
//    res_valid=0; res_sum=0; busy=0; err=0.
//  FSM: IDLE -> FEED -> DRAIN -> RESULT -> IDLE.
//  IDLE: on cmd_valid, latch B=min(cmd_beats,MAX_BEATS), clear acc, clear issue count, clear return count.
//    B=0 -> RESULT with res_sum=0. Else -> FEED.
//  FEED: each in_valid & in_ready cycle issues one beat and increments the issue count.
//    in_valid gaps are allowed; the tree sees start=0 in those cycles.
//  Return: any cycle in FEED/DRAIN with tree_start_out=1 adds sign-extended tree_sum to acc and increments the return count.
//    Issue and return in the same cycle are both processed.
//  FEED exit on the cycle the B-th beat issues:
//    - B-th return also seen this cycle (TREE_LATENCY=0) -> RESULT.
//    - Otherwise -> DRAIN.
//  DRAIN: in_ready=0. On the B-th return -> RESULT.
//  Entering RESULT: res_sum is registered as acc plus the final return. res_valid=1 from the next cycle.
//  Latency: first beat issued at cycle 0 with no input gaps -> res_valid at cycle B+TREE_LATENCY.
//  RESULT: res_sum and res_valid are held stable while res_ready=0.
//    On res_valid & res_ready -> IDLE; res_valid drops next cycle.
//    A new command is accepted only after handover; cmd_ready is never combinationally tied to res_ready.
//  Tree has no backpressure. Returns are always absorbed, never dropped.
//  Spurious tree_start_out (IDLE, RESULT, or after B returns): acc unchanged, err=1 until rst.
//  Width: ACC_WIDTH holds MAX_BEATS*NUM_INPUTS*(-2^(INPUT_WIDTH-1)) exactly. No saturation needed.
//  Reset mid-command: immediate return to IDLE; partial acc is discarded.
//    Tokens still in flight in the tree after rst deasserts are treated as spurious (err=1).
//    The system resets the tree with the same event so that no such tokens exist.
// TESTING  (NUM_INPUTS=8, INPUT_WIDTH=8, TREE_LATENCY=2, MAX_BEATS=16, real pipelined tree with 2 mask bits set)
//  1. B=4, in_valid held, all lanes=1 -> res_sum=32; res_valid rises at cycle 6 after first issue.
//  2. B=16, all lanes=-128 -> res_sum=-16384 (ACC_WIDTH=15 minimum), err=0.
//  3. B=3, lanes=beat index (0,1,2), 2-cycle in_valid gaps, res_ready low 5 cycles -> res_sum=24.
//     res_sum stays stable through the stall; cmd_ready stays 0 until handover.
//  4. cmd_beats=0 -> res_valid next cycle with res_sum=0; cmd_beats=31 -> exactly 16 beats accepted.
//  5. Assert rst after 2 of 4 beats -> all outputs at reset values.
//     A new B=1 command with lanes=5 then returns res_sum=40.
//  6. TREE_LATENCY=0 with a combinational tree, B=2, lanes=3 -> res_sum=48 with no DRAIN cycle.
//     Then force tree_start_out in IDLE -> err=1 and stays 1.

Source files
------------

// File: rtl/adder_tree_reduce_ctrl_if.sv
// Handshake bundle between the vector source, the adder tree, the result
// consumer and the reduction controller.
interface adder_tree_reduce_ctrl_if #(
  parameter int NUM_INPUTS  = 8,
  parameter int INPUT_WIDTH = 8,
  parameter int MAX_BEATS   = 16
);
  localparam int TREE_WIDTH = INPUT_WIDTH + $clog2(NUM_INPUTS);
  localparam int ACC_WIDTH  = TREE_WIDTH + $clog2(MAX_BEATS);
  localparam int CNT_WIDTH  = $clog2(MAX_BEATS + 1);

  logic                              cmd_valid;
  logic                              cmd_ready;
  logic [CNT_WIDTH-1:0]              cmd_beats;
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_INPUTS*INPUT_WIDTH-1:0] in_data;
  logic [NUM_INPUTS*INPUT_WIDTH-1:0] tree_inputs;
  logic                              tree_start;
  logic [TREE_WIDTH-1:0]             tree_sum;
  logic                              tree_start_out;
  logic                              res_valid;
  logic                              res_ready;
  logic [ACC_WIDTH-1:0]              res_sum;
  logic                              busy;
  logic                              err;

  // Controller side
  modport slave (
    input  cmd_valid, cmd_beats, in_valid, in_data, tree_sum, tree_start_out, res_ready,
    output cmd_ready, in_ready, tree_inputs, tree_start, res_valid, res_sum, busy, err
  );

  // Environment side: source, tree and result consumer
  modport master (
    output cmd_valid, cmd_beats, in_valid, in_data, tree_sum, tree_start_out, res_ready,
    input  cmd_ready, in_ready, tree_inputs, tree_start, res_valid, res_sum, busy, err
  );
endinterface

// File: rtl/adder_tree_reduce_ctrl.sv
// Streams B beats through one adder tree, accumulates the B returned partial
// sums and presents the signed total on a valid/ready result port.
module adder_tree_reduce_ctrl #(
  parameter int NUM_INPUTS   = 8,
  parameter int INPUT_WIDTH  = 8,
  parameter int TREE_LATENCY = 2,
  parameter int MAX_BEATS    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  adder_tree_reduce_ctrl_if.slave   io_bus
);
  localparam int TREE_WIDTH = INPUT_WIDTH + $clog2(NUM_INPUTS);
  localparam int ACC_WIDTH  = TREE_WIDTH + $clog2(MAX_BEATS);
  localparam int CNT_WIDTH  = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_RESULT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_beats;
  logic [CNT_WIDTH-1:0]  r_issue_cnt;
  logic [CNT_WIDTH-1:0]  r_ret_cnt;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic                  r_err;

  logic                  w_cmd_take;
  logic [CNT_WIDTH-1:0]  w_beats_sat;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_expect;
  logic                  w_ret;
  logic                  w_spurious;
  logic [CNT_WIDTH-1:0]  w_ret_cnt_nxt;
  logic                  w_all_ret;
  logic [ACC_WIDTH-1:0]  w_sum_ext;

  assign w_cmd_take    = (r_state == S_IDLE) && io_bus.cmd_valid;
  assign w_beats_sat   = (io_bus.cmd_beats > CNT_WIDTH'(MAX_BEATS)) ? CNT_WIDTH'(MAX_BEATS)
                                                                    : io_bus.cmd_beats;
  assign w_issue       = io_bus.in_valid && (r_state == S_FEED);
  assign w_last_issue  = w_issue && (r_issue_cnt == r_beats - CNT_WIDTH'(1));

  // A token is only wanted while a command still owes returns.
  assign w_expect      = ((r_state == S_FEED) || (r_state == S_DRAIN)) && (r_ret_cnt < r_beats);
  assign w_ret         = io_bus.tree_start_out && w_expect;
  assign w_spurious    = io_bus.tree_start_out && !w_expect;
  assign w_ret_cnt_nxt = r_ret_cnt + CNT_WIDTH'(w_ret);
  assign w_all_ret     = (w_ret_cnt_nxt == r_beats);
  assign w_sum_ext     = {{(ACC_WIDTH-TREE_WIDTH){io_bus.tree_sum[TREE_WIDTH-1]}}, io_bus.tree_sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (io_bus.cmd_valid) w_state_nxt = (w_beats_sat == '0) ? S_RESULT : S_FEED;
      S_FEED:   if (w_last_issue)
                  w_state_nxt = (TREE_LATENCY == 0 && w_all_ret) ? S_RESULT : S_DRAIN;
      S_DRAIN:  if (w_all_ret) w_state_nxt = S_RESULT;
      S_RESULT: if (io_bus.res_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beats     <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_acc       <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_cmd_take) begin
        r_beats     <= w_beats_sat;
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
        r_acc       <= '0;
      end else begin
        if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_WIDTH'(1);
        if (w_ret) begin
          r_ret_cnt <= w_ret_cnt_nxt;
          r_acc     <= r_acc + w_sum_ext;
        end
      end
      if (w_spurious) r_err <= 1'b1;
    end
  end

  // The accumulator already holds the final total once RESULT is entered.
  assign io_bus.cmd_ready   = (r_state == S_IDLE);
  assign io_bus.in_ready    = (r_state == S_FEED);
  assign io_bus.tree_inputs = io_bus.in_data;
  assign io_bus.tree_start  = w_issue;
  assign io_bus.res_valid   = (r_state == S_RESULT);
  assign io_bus.res_sum     = r_acc;
  assign io_bus.busy        = (r_state != S_IDLE);
  assign io_bus.err         = r_err;
endmodule

// File: tb/tb_adder_tree_reduce_ctrl.sv
// Directed bench: a 2-stage pipelined tree model drives one controller, a
// combinational tree drives a second controller built for zero tree latency.
module tb_adder_tree_reduce_ctrl;
  localparam int NI = 8;
  localparam int IW = 8;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst;
  logic force_tok;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_tree_reduce_ctrl_if #(.NUM_INPUTS(NI), .INPUT_WIDTH(IW), .MAX_BEATS(MB)) bus2 ();
  adder_tree_reduce_ctrl_if #(.NUM_INPUTS(NI), .INPUT_WIDTH(IW), .MAX_BEATS(MB)) bus0 ();

  adder_tree_reduce_ctrl #(.NUM_INPUTS(NI), .INPUT_WIDTH(IW), .TREE_LATENCY(2), .MAX_BEATS(MB))
    u_dut (.clk(clk), .rst(rst), .io_bus(bus2));
  adder_tree_reduce_ctrl #(.NUM_INPUTS(NI), .INPUT_WIDTH(IW), .TREE_LATENCY(0), .MAX_BEATS(MB))
    u_dut0 (.clk(clk), .rst(rst), .io_bus(bus0));

  function automatic logic signed [10:0] lane_sum(input logic [63:0] d);
    logic signed [10:0] s;
    s = '0;
    for (int k = 0; k < NI; k++) s = s + 11'($signed(d[k*IW +: IW]));
    return s;
  endfunction

  function automatic logic [63:0] splat(input logic [7:0] v);
    return {8{v}};
  endfunction

  // Pipelined tree with two registered stages, reset together with the controller
  logic signed [10:0] r_s1, r_s2;
  logic               r_v1, r_v2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0; r_s2 <= '0; r_v1 <= 1'b0; r_v2 <= 1'b0;
    end else begin
      r_s1 <= lane_sum(bus2.tree_inputs);
      r_v1 <= bus2.tree_start;
      r_s2 <= r_s1;
      r_v2 <= r_v1;
    end
  end
  assign bus2.tree_sum       = r_s2;
  assign bus2.tree_start_out = r_v2;

  assign bus0.tree_sum       = lane_sum(bus0.tree_inputs);
  assign bus0.tree_start_out = bus0.tree_start | force_tok;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input int beats);
    @(negedge clk);
    bus2.cmd_valid = 1'b1;
    bus2.cmd_beats = 5'(beats);
    @(negedge clk);
    bus2.cmd_valid = 1'b0;
  endtask

  task automatic feed_beat(input logic [63:0] d, input int gap);
    int t = 0;
    while (!bus2.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus2.in_ready) check("in_ready_timeout", longint'(bus2.in_ready), 1);
    bus2.in_valid = 1'b1;
    bus2.in_data  = d;
    @(negedge clk);
    if (gap > 0) begin
      bus2.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_result(input string tag, output int at_cyc);
    int t = 0;
    while (!bus2.res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus2.res_valid) check(tag, longint'(bus2.res_valid), 1);
    at_cyc = cyc;
  endtask

  task automatic handover(input string tag);
    bus2.res_ready = 1'b1;
    @(negedge clk);
    bus2.res_ready = 1'b0;
    check({tag, "_res_valid_drop"}, longint'(bus2.res_valid), 0);
    check({tag, "_cmd_ready_back"}, longint'(bus2.cmd_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, longint'(bus2.cmd_ready), 1);
    check({tag, "_in_ready"},  longint'(bus2.in_ready), 0);
    check({tag, "_tree_start"}, longint'(bus2.tree_start), 0);
    check({tag, "_res_valid"}, longint'(bus2.res_valid), 0);
    check({tag, "_res_sum"},   longint'($signed(bus2.res_sum)), 0);
    check({tag, "_busy"},      longint'(bus2.busy), 0);
    check({tag, "_err"},       longint'(bus2.err), 0);
  endtask

  initial begin
    int c0, c1, cnt;
    logic seen_drain;

    rst = 1'b1;
    force_tok = 1'b0;
    bus2.cmd_valid = 1'b0; bus2.cmd_beats = '0; bus2.in_valid = 1'b0;
    bus2.in_data = '0; bus2.res_ready = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_beats = '0; bus0.in_valid = 1'b0;
    bus0.in_data = '0; bus0.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // 1: four beats of all-ones lanes, in_valid held
    send_cmd(4);
    c0 = cyc;
    for (int i = 0; i < 4; i++) feed_beat(splat(8'd1), 0);
    bus2.in_valid = 1'b0;
    wait_result("t1_timeout", c1);
    check("t1_latency", longint'(c1 - c0), 6);
    check("t1_sum", longint'($signed(bus2.res_sum)), 32);
    check("t1_busy", longint'(bus2.busy), 1);
    check("t1_cmd_ready", longint'(bus2.cmd_ready), 0);
    handover("t1");

    // 2: full-length command of most-negative lanes
    send_cmd(16);
    for (int i = 0; i < 16; i++) feed_beat(splat(8'h80), 0);
    bus2.in_valid = 1'b0;
    wait_result("t2_timeout", c1);
    check("t2_sum", longint'($signed(bus2.res_sum)), -16384);
    check("t2_err", longint'(bus2.err), 0);
    handover("t2");

    // 3: lanes = beat index, input gaps, consumer stall with a command waiting
    send_cmd(3);
    for (int i = 0; i < 3; i++) feed_beat(splat(8'(i)), 2);
    bus2.in_valid = 1'b0;
    wait_result("t3_timeout", c1);
    bus2.cmd_valid = 1'b1;
    bus2.cmd_beats = 5'd1;
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_sum", longint'($signed(bus2.res_sum)), 24);
      check("t3_stall_valid", longint'(bus2.res_valid), 1);
      check("t3_stall_cmd_ready", longint'(bus2.cmd_ready), 0);
      @(negedge clk);
    end
    bus2.cmd_valid = 1'b0;
    handover("t3");

    // 4a: zero-beat command
    send_cmd(0);
    check("t4a_valid", longint'(bus2.res_valid), 1);
    check("t4a_sum", longint'($signed(bus2.res_sum)), 0);
    handover("t4a");

    // 4b: oversized beat count saturates to MAX_BEATS
    send_cmd(31);
    cnt = 0;
    repeat (24) begin
      if (bus2.in_ready) begin
        bus2.in_valid = 1'b1;
        bus2.in_data  = splat(8'd1);
        cnt++;
      end else begin
        bus2.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus2.in_valid = 1'b0;
    check("t4b_beats_taken", longint'(cnt), 16);
    wait_result("t4b_timeout", c1);
    check("t4b_sum", longint'($signed(bus2.res_sum)), 128);
    handover("t4b");

    // 5: reset in the middle of a command, then a fresh one
    send_cmd(4);
    for (int i = 0; i < 2; i++) feed_beat(splat(8'd1), 0);
    bus2.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_err_after_rst", longint'(bus2.err), 0);
    send_cmd(1);
    feed_beat(splat(8'd5), 0);
    bus2.in_valid = 1'b0;
    wait_result("t5_timeout", c1);
    check("t5_sum", longint'($signed(bus2.res_sum)), 40);
    check("t5_err", longint'(bus2.err), 0);
    handover("t5");

    // 6: combinational tree, no DRAIN expected; then a spurious token in IDLE
    @(negedge clk);
    bus0.cmd_valid = 1'b1;
    bus0.cmd_beats = 5'd2;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    c0 = cyc;
    seen_drain = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = splat(8'd3);
      @(negedge clk);
      if (bus0.busy && !bus0.in_ready && !bus0.res_valid) seen_drain = 1'b1;
    end
    bus0.in_valid = 1'b0;
    check("t6_valid", longint'(bus0.res_valid), 1);
    check("t6_latency", longint'(cyc - c0), 2);
    check("t6_sum", longint'($signed(bus0.res_sum)), 48);
    check("t6_drain_seen", longint'(seen_drain), 0);
    bus0.res_ready = 1'b1;
    @(negedge clk);
    bus0.res_ready = 1'b0;
    check("t6_err_before", longint'(bus0.err), 0);
    force_tok = 1'b1;
    @(negedge clk);
    force_tok = 1'b0;
    check("t6_err_set", longint'(bus0.err), 1);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", longint'(bus0.err), 1);
    check("t6_sum_unchanged", longint'($signed(bus0.res_sum)), 48);
    check("t6_other_err", longint'(bus2.err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
